// File: rtl/comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cmp_state_e;

    // Width of a counter that must hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparator_if.sv
// Operand/result handshake bundle for comparator_seq.
// The master side presents operands and consumes results; the slave side is the comparator.
interface comparator_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             less;
    logic             equal;
    logic             greater;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, less, equal, greater
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, less, equal, greater
    );
endinterface

// File: rtl/comparator_digit.sv
// Combinational compare of one DIGIT-bit slice of each operand (unsigned).
module comparator_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    output logic             digit_lt,
    output logic             digit_eq
);
    assign digit_lt = (a_d < b_d);
    assign digit_eq = (a_d == b_d);
endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: walks both operands MSB-first, DIGIT bits per
// cycle. Signed mode flips both sign bits at capture so the walk stays unsigned.
// Optional build macro CMP_EARLY_EXIT_EN: finish as soon as the first differing
// digit is seen instead of always walking all NDIG digits.
module comparator_seq
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    comparator_if.slave  bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if ((DIGIT < 1) || (WIDTH < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("comparator_seq: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    cmp_state_e       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             acc_eq_reg;
    logic             acc_lt_reg;
    logic             less_reg;
    logic             equal_reg;
    logic             greater_reg;

    logic             acc_eq_next;
    logic             acc_lt_next;
    logic             run_done;
    logic [CW-1:0]    digit_idx;
    logic [WIDTH-1:0] sign_flip;
    logic             digit_lt;
    logic             digit_eq;

    logic [DIGIT-1:0] a_dig [NDIG];
    logic [DIGIT-1:0] b_dig [NDIG];

    // Split the captured operands into digits; index 0 is the least significant.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            assign a_dig[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_dig[gi] = b_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    // MSB-first walk: the first RUN cycle looks at the top digit.
    assign digit_idx = LAST - cnt_reg;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    assign sign_flip = bus.is_signed ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    comparator_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d      (a_dig[digit_idx]),
        .b_d      (b_dig[digit_idx]),
        .digit_lt (digit_lt),
        .digit_eq (digit_eq)
    );

    // Once a digit differs, the verdict is frozen; lower digits cannot change it.
    always_comb begin
        acc_lt_next = acc_lt_reg;
        acc_eq_next = acc_eq_reg;
        if (acc_eq_reg) begin
            acc_lt_next = digit_lt;
            acc_eq_next = digit_eq;
        end
    end

`ifdef CMP_EARLY_EXIT_EN
    assign run_done = (cnt_reg == LAST) || (acc_eq_reg && !digit_eq);
`else
    assign run_done = (cnt_reg == LAST);
`endif

    // Control FSM, operand capture, digit accumulation and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_eq_reg  <= 1'b0;
            acc_lt_reg  <= 1'b0;
            less_reg    <= 1'b0;
            equal_reg   <= 1'b0;
            greater_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.a ^ sign_flip;
                        b_reg      <= bus.b ^ sign_flip;
                        acc_eq_reg <= 1'b1;
                        acc_lt_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    acc_eq_reg  <= acc_eq_next;
                    acc_lt_reg  <= acc_lt_next;
                    cnt_reg     <= cnt_reg + CW'(1);
                    less_reg    <= acc_lt_next;
                    equal_reg   <= acc_eq_next;
                    greater_reg <= !acc_lt_next && !acc_eq_next;
                    if (run_done) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.less      = less_reg;
    assign bus.equal     = equal_reg;
    assign bus.greater   = greater_reg;

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Parametrised, multi-cycle magnitude comparator. Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, in signed or unsigned mode.
- Uses a valid/ready handshake on input and output.
- Successor to the fixed 32-bit unsigned combinational comparator. Used where area matters more than latency, e.g. iterative ALU/divider helpers and slow-path branch-compare units.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥1.
- DIGIT, 4, bits compared per cycle; must be ≥1 and divide WIDTH exactly. Elaboration error otherwise.
- NDIG (derived, localparam), WIDTH/DIGIT, number of compare cycles.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- less  out  1  A < B.
- equal  out  1  A == B.
- greater  out  1  A > B.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, digit counter=0, operand regs=0, less=0, equal=0, greater=0, out_valid=0. in_ready=1 once rst deasserts.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept (IDLE, in_valid=1) on an edge:
  - Latch a and b. If is_signed=1, invert the MSB of both latched operands; the compare is then unsigned on the modified values.
  - Set acc_eq=1, acc_lt=0, cnt=0. Go to RUN.
- RUN, per edge:
  - Take digit k = NDIG-1-cnt (bits [k*DIGIT+DIGIT-1 : k*DIGIT]) of both operands.
  - If acc_eq=1: acc_lt=digit_lt, acc_eq=digit_eq. Otherwise hold both.
  - cnt++. On the edge where cnt==NDIG-1: go to DONE.
  - Register less=acc_lt_next, equal=acc_eq_next, greater=!less_next&!equal_next.
- Latency: out_valid rises exactly NDIG edges after the accept edge (feature off).
- DONE: outputs held stable while out_ready=0. On an edge with out_ready=1: go to IDLE, out_valid=0.
  - Result outputs keep their last value after handshake; they are only meaningful while out_valid=1.
- No overlap: a new accept is possible only from IDLE. Peak throughput is one result per NDIG+2 cycles.
- in_valid while not in_ready: ignored; the producer must hold.
- rst mid-RUN or in DONE: abort. Next cycle matches reset values and the result is discarded.
- WIDTH==DIGIT: NDIG=1, single RUN cycle.
- Exactly one of less/equal/greater is 1 whenever out_valid=1.

Optional Feature:
- Macro CMP_EARLY_EXIT_EN.
- Defined: in RUN, if the current digit differs (digit_eq=0) while acc_eq=1, go to DONE on that edge with final results registered. Latency = index of first differing digit from MSB + 1. Equal operands still take NDIG edges.
- Undefined: fixed NDIG-edge latency always; the early-exit logic is not synthesised.

Decomposition:
- Package comparator_pkg holds:
  - cmp_state_e enum {IDLE, RUN, DONE}.
  - Function clog2-based counter width helper.
- Sub-module comparator_digit (parameter DIGIT): combinational.
  - Inputs: a_d, b_d [DIGIT-1:0].
  - Outputs: digit_lt, digit_eq.
  - Instantiated once in the datapath. The FSM and accumulators live in comparator_seq.

Test Plan (WIDTH=32, DIGIT=4, NDIG=8):
- Unsigned: a=0x0000_0001, b=0xFFFF_FFFF, is_signed=0 → less=1, equal=0, greater=0; out_valid exactly 8 edges after accept.
- Signed: same operands, is_signed=1 → greater=1 (1 > -1); signed a=0x8000_0000, b=0x7FFF_FFFF → less=1.
- Equal: a=b=0xDEAD_BEEF, both modes → equal=1 after 8 edges, with and without CMP_EARLY_EXIT_EN.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → less/equal/greater/out_valid stable, in_ready=0, in_valid pulses ignored. Release → IDLE next edge; the next op is accepted and correct.
- Reset: assert rst at RUN cnt=3 → next cycle out_valid=0, in_ready=1, outputs 0. A new compare a=5, b=9 → less=1.
- Early exit: a=0x8000_0000, b=0, unsigned → with CMP_EARLY_EXIT_EN, out_valid 1 edge after accept, greater=1. Without it, 8 edges after accept, same result.
